// File: rtl/mem8_access_ctrl_pkg.sv
// Shared definitions for the 8-bit memory access controller: data width,
// default geometry and the controller state encoding.
package mem8_access_ctrl_pkg;

    localparam int DATA_W     = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/mem8_access_ctrl_beat_ctr.sv
// Loadable down-counter with a zero flag; counts remaining burst beats and
// the read-latency wait inside the access controller.
module mem8_access_ctrl_beat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load wins over decrement; a decrement at zero holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem8_access_ctrl.sv
// Requester-side controller for the 8-bit synchronous memory: turns single or
// burst commands into memory strobes and returns read bytes on a response handshake.
module mem8_access_ctrl
    import mem8_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_r, state_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                done_r, done_s;
    logic                mem_en_r, mem_en_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                rsp_last_r, rsp_last_s;
    logic [DATA_W-1:0]   rsp_data_r, rsp_data_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   fill_r, fill_s;
    logic [ADDR_W-1:0]   addr_inc_s;
    logic                beat_load_s, beat_dec_s, beat_zero_s;
    logic                lat_load_s, lat_dec_s, lat_zero_s;

    // Natural ADDR_W-bit overflow gives the wrap from the top address to 0.
    assign addr_inc_s = addr_r + ADDR_W'(1'b1);

    mem8_access_ctrl_beat_ctr #(.W(LEN_W)) u_beat_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load_s),
        .load_val (cmd_len),
        .dec      (beat_dec_s),
        .zero     (beat_zero_s)
    );

    mem8_access_ctrl_beat_ctr #(.W(LAT_W)) u_lat_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load_s),
        .load_val (LAT_W'(RD_LAT - 1)),
        .dec      (lat_dec_s),
        .zero     (lat_zero_s)
    );

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = 1'b0;
        done_s      = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        rsp_valid_s = 1'b0;
        rsp_last_s  = 1'b0;
        rsp_data_s  = rsp_data_r;
        addr_s      = addr_r;
        fill_s      = fill_r;
        beat_load_s = 1'b0;
        beat_dec_s  = 1'b0;
        lat_load_s  = 1'b0;
        lat_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    beat_load_s = 1'b1;
                    addr_s      = cmd_addr;
                    fill_s      = cmd_wdata;
                    mem_en_s    = 1'b1;
                    mem_addr_s  = cmd_addr;
                    if (cmd_write) begin
                        state_s     = ST_WRITE;
                        mem_we_s    = 1'b1;
                        mem_wdata_s = cmd_wdata;
                    end else begin
                        state_s     = ST_ISSUE;
                    end
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            ST_WRITE: begin
                if (beat_zero_s) begin
                    state_s     = ST_IDLE;
                    done_s      = 1'b1;
                    cmd_ready_s = 1'b1;
                end else begin
                    beat_dec_s  = 1'b1;
                    addr_s      = addr_inc_s;
                    mem_en_s    = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = addr_inc_s;
                    mem_wdata_s = fill_r;
                end
            end
            ST_ISSUE: begin
                lat_load_s = 1'b1;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // The last wait cycle is the one in which mem_rdata is valid.
                if (lat_zero_s) begin
                    rsp_data_s  = mem_rdata;
                    rsp_valid_s = 1'b1;
                    rsp_last_s  = beat_zero_s;
                    state_s     = ST_RESP;
                end else begin
                    lat_dec_s   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (beat_zero_s) begin
                        state_s     = ST_IDLE;
                        done_s      = 1'b1;
                        cmd_ready_s = 1'b1;
                    end else begin
                        beat_dec_s  = 1'b1;
                        addr_s      = addr_inc_s;
                        mem_en_s    = 1'b1;
                        mem_addr_s  = addr_inc_s;
                        state_s     = ST_ISSUE;
                    end
                end else begin
                    rsp_valid_s = 1'b1;
                    rsp_last_s  = rsp_last_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            done_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            fill_r      <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            done_r      <= done_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_last_r  <= rsp_last_s;
            rsp_data_r  <= rsp_data_s;
            addr_r      <= addr_s;
            fill_r      <= fill_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign done      = done_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_last  = rsp_last_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_mem8_access_ctrl.sv
// Scoreboard bench for mem8_access_ctrl: memory models behind two instances
// (RD_LAT=1 and RD_LAT=3), expected writes/read bytes queued at command accept.
module tb_mem8_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_init = 1'b1;

    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'd0, cmd_len = 4'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_last;
    logic [7:0] rsp_data;
    logic       mem_en, mem_we, done;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic       b_cmd_valid = 1'b0, b_cmd_ready;
    logic       b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_last;
    logic [7:0] b_rsp_data;
    logic       b_mem_en, b_mem_we, b_done;
    logic [3:0] b_mem_addr;
    logic [7:0] b_mem_wdata, b_mem_rdata, b_p0, b_p1;

    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];
    logic [7:0]  ref_mem [16];
    logic [11:0] wq [$];
    logic [8:0]  rq [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem8_access_ctrl #(.ADDR_W(4), .LEN_W(4), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .done(done)
    );

    mem8_access_ctrl #(.ADDR_W(4), .LEN_W(4), .RD_LAT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(1'b0),
        .cmd_addr(4'd1), .cmd_len(4'd0), .cmd_wdata(8'd0),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .done(b_done)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'h76 + 8'(i);
    endfunction

    // Memory behind the RD_LAT=1 instance: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= init_byte(i);
        end else if (mem_en && mem_we) begin
            mem_a[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= mem_a[mem_addr];
    end

    // Memory behind the RD_LAT=3 instance: read data pipelined three deep.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= init_byte(i);
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
        end
        b_p0        <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : b_p0;
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic wr, input logic [3:0] addr, input logic [3:0] len,
                            input logic [7:0] wdata);
        logic [3:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 4'(i);
            if (wr) begin
                ref_mem[a] = wdata;
                wq.push_back({a, wdata});
            end else begin
                rq.push_back({(i == int'(len)), ref_mem[a]});
            end
        end
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len,
                            input logic [7:0] wdata);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_val("cmd_accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        push_exp(wr, addr, len, wdata);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, done, 1);
    endtask

    // Scoreboard: every memory write and every response handshake is matched in order.
    always @(negedge clk) begin
        logic [11:0] w;
        logic [8:0]  r;
        if (rst_n && !mem_init) begin
            check_val("we_implies_en", {31'd0, mem_we & ~mem_en}, 0);
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    check_val("write_expected", {31'd0, (wq.size() != 0)}, 1);
                end else begin
                    w = wq.pop_front();
                    check_val("wr_addr", mem_addr, w[11:8]);
                    check_val("wr_data", mem_wdata, w[7:0]);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    check_val("rsp_expected", {31'd0, (rq.size() != 0)}, 1);
                end else begin
                    r = rq.pop_front();
                    check_val("rsp_data", rsp_data, r[7:0]);
                    check_val("rsp_last", rsp_last, r[8]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ea;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_byte(i);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_outputs", {rsp_valid, rsp_last, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, done}, 0);
        rst_n = 1'b1;
        check_val("rel_cmd_ready_pre_edge", cmd_ready, 0);
        tick();
        check_val("rel_cmd_ready", cmd_ready, 1);

        // single write
        send_cmd(1'b1, 4'h3, 4'h0, 8'hA5);
        check_val("t1_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h3, 8'hA5});
        tick();
        check_val("t1_done", {done, cmd_ready, mem_en}, 3'b110);
        tick();
        check_val("t1_done_pulse", done, 0);

        // single read, RD_LAT=1
        send_cmd(1'b0, 4'h1, 4'h0, 8'h00);
        check_val("t3_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 4'h1});
        tick();
        check_val("t3_wait", {rsp_valid, mem_en}, 2'b00);
        tick();
        check_val("t3_rsp", {rsp_valid, rsp_last, rsp_data}, {1'b1, 1'b1, 8'h77});
        rsp_ready = 1'b1;
        tick();
        check_val("t3_done", {done, cmd_ready, rsp_valid}, 3'b110);
        rsp_ready = 1'b0;

        // 3-beat read with a 5-cycle stall on beat 1
        send_cmd(1'b0, 4'h0, 4'h2, 8'h00);
        for (int n = 0; n < 50 && !rsp_valid; n++) tick();
        for (int k = 0; k < 5; k++) begin
            check_val("t4_stall", {rsp_valid, rsp_last, mem_en, rsp_data}, {1'b1, 1'b0, 1'b0, ref_mem[0]});
            tick();
        end
        rsp_ready = 1'b1;
        wait_done("t4_done");
        rsp_ready = 1'b0;

        // write fill wrapping past the top address
        send_cmd(1'b1, 4'hE, 4'h3, 8'h5C);
        for (int i = 0; i < 4; i++) begin
            ea = 4'hE + 4'(i);
            check_val("t2_beat", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, ea});
            tick();
        end
        check_val("t2_done", {done, cmd_ready, mem_en}, 3'b110);

        // read back across the wrap, rsp_ready high before rsp_valid
        rsp_ready = 1'b1;
        send_cmd(1'b0, 4'hE, 4'h3, 8'h00);
        wait_done("t2_readback_done");
        rsp_ready = 1'b0;

        // second command held valid while the first burst is busy
        send_cmd(1'b1, 4'h5, 4'h3, 8'h11);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h9; cmd_len = 4'h0; cmd_wdata = 8'h22;
        push_exp(1'b1, 4'h9, 4'h0, 8'h22);
        for (int i = 0; i < 4; i++) begin
            check_val("t6_busy_ready", cmd_ready, 0);
            tick();
        end
        check_val("t6_first_done", {done, cmd_ready}, 2'b11);
        tick();
        check_val("t6_second", {mem_en, mem_addr, mem_wdata, cmd_ready}, {1'b1, 4'h9, 8'h22, 1'b0});
        cmd_valid = 1'b0;
        wait_done("t6_second_done");

        // async reset in the middle of a read burst
        send_cmd(1'b0, 4'h4, 4'h3, 8'h00);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_async_rst", {cmd_ready, rsp_valid, rsp_last, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, done}, 0);
        rq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("t5_rel_pre_edge", cmd_ready, 0);
        tick();
        check_val("t5_rel", {cmd_ready, rsp_valid, done}, 3'b100);
        tick();
        check_val("t5_no_stale_rsp", rsp_valid, 0);

        // single read on the RD_LAT=3 instance
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        check_val("lat3_issue", {b_mem_en, b_mem_we, b_mem_addr}, {1'b1, 1'b0, 4'h1});
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_val("lat3_wait", b_rsp_valid, 0);
        end
        tick();
        check_val("lat3_rsp", {b_rsp_valid, b_rsp_last, b_rsp_data}, {1'b1, 1'b1, 8'h77});
        b_rsp_ready = 1'b1;
        tick();
        check_val("lat3_done", {b_done, b_cmd_ready, b_rsp_valid}, 3'b110);
        b_rsp_ready = 1'b0;

        tick();
        check_val("wq_drained", wq.size(), 0);
        check_val("rq_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
